hs_packet_arbiter: RTL

HS_PACKET_ARBITER -- requirements
Module: hs_packet_arbiter

---
 rtl/hs_arb_pkg.sv | 32 +++
 rtl/hs_packet_arbiter_rr_pick.sv | 25 ++
 rtl/hs_packet_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hs_arb_pkg.sv
// rtl/hs_arb_pkg.sv - shared types, constants and round-robin pick function for the packet arbiter
package hs_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int CNT_W     = 16;
  localparam int MAX_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  // First requester after last_grant, wrapping modulo n_ports; all zeros when nobody asks.
  function automatic logic [MAX_PORTS-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input port_idx_t            last_grant,
    input int                   n_ports
  );
    logic [MAX_PORTS-1:0] gnt;
    port_idx_t            idx;
    gnt = '0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      idx = port_idx_t'((int'(last_grant) + k) % n_ports);
      if (k <= n_ports && gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/hs_packet_arbiter_rr_pick.sv
// rtl/hs_packet_arbiter_rr_pick.sv - combinational round-robin priority select
module hs_rr_pick
  import hs_arb_pkg::*;
#(
  parameter int N_PORTS = 3
) (
  input  logic [N_PORTS-1:0] req,
  input  port_idx_t          last_grant,
  output logic [N_PORTS-1:0] gnt,
  output logic               found
);

  logic [MAX_PORTS-1:0] req_ext;
  logic [MAX_PORTS-1:0] gnt_ext;

  // Widen the request mask to the function's fixed width and narrow the grant back.
  always_comb begin
    req_ext                = '0;
    req_ext[N_PORTS-1:0]   = req;
    gnt_ext                = rr_pick(req_ext, last_grant, N_PORTS);
    gnt                    = gnt_ext[N_PORTS-1:0];
    found                  = |gnt_ext;
  end

endmodule

// File: rtl/hs_packet_arbiter.sv
// rtl/hs_packet_arbiter.sv - packet-granular round-robin merge of N requester streams
module hs_packet_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_PORTS = 3,
  parameter int DW      = 32
) (
  input  logic                     clk,
  input  logic                     MIB_MASTER_RESET,
  input  logic [N_PORTS*DW-1:0]    i_data,
  input  logic [N_PORTS-1:0]       i_last,
  input  logic [N_PORTS-1:0]       i_valid,
  output logic [N_PORTS-1:0]       o_ready_req,
  input  logic [N_PORTS-1:0]       i_port_en,
  output logic [DW-1:0]            o_data,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [N_PORTS-1:0]       o_grant,
  output logic [N_PORTS*CNT_W-1:0] o_pkt_cnt
);

  arb_state_e               state_q, state_d;
  logic [N_PORTS-1:0]       grant_q, grant_d;
  port_idx_t                last_grant_q, last_grant_d;
  logic [DW-1:0]            data_q, data_d;
  logic                     last_q, last_d;
  logic                     valid_q, valid_d;
  logic [N_PORTS*CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [N_PORTS-1:0]       pick_gnt;
  logic                     pick_found;
  logic                     sel_valid;
  logic                     sel_last;
  logic [DW-1:0]            sel_data;
  port_idx_t                g_idx;
  logic                     ready_g;
  logic                     ld;
  logic                     done;

  hs_rr_pick #(
    .N_PORTS (N_PORTS)
  ) u_pick (
    .req        (i_valid & i_port_en),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .found      (pick_found)
  );

  // Route the granted requester onto the shared side; the enable mask is not consulted here.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    g_idx     = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant_q[p]) begin
        sel_valid = i_valid[p];
        sel_last  = i_last[p];
        sel_data  = i_data[p*DW +: DW];
        g_idx     = port_idx_t'(p);
      end
    end
    ready_g = (state_q == ARB_BUSY) && (!valid_q || i_ready);
    ld      = ready_g && sel_valid;
    done    = ld && sel_last;
  end

  // Next-state: IDLE picks an owner, BUSY loads words until the last one is taken.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    data_d       = ld ? sel_data : data_q;
    last_d       = ld ? sel_last : last_q;
    valid_d      = ld ? 1'b1 : ((valid_q && i_ready) ? 1'b0 : valid_q);
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_d      = ARB_IDLE;
          grant_d      = '0;
          last_grant_d = g_idx;
          for (int p = 0; p < N_PORTS; p++) begin
            if (grant_q[p]) begin
              pkt_cnt_d[p*CNT_W +: CNT_W] = pkt_cnt_q[p*CNT_W +: CNT_W] + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state and registered output stage; reset leaves port 0 with first priority.
  always_ff @(posedge clk or negedge MIB_MASTER_RESET) begin
    if (!MIB_MASTER_RESET) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= port_idx_t'(N_PORTS - 1);
      data_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign o_ready_req = ready_g ? grant_q : '0;
  assign o_data      = data_q;
  assign o_last      = last_q;
  assign o_valid     = valid_q;
  assign o_grant     = grant_q;
  assign o_pkt_cnt   = pkt_cnt_q;

endmodule
